// File: rtl/orgate_checker.sv
// orgate_checker: response monitor for the 3-bit OR-gate lab core.
// Each accepted sample (a, b, c) is checked against the expected value a|b.
// The monitor counts accepted vectors and mismatches over a run of
// NUM_VECTORS samples, and it captures the first failing vector.
// Optional build macro: ORGATE_CHECKER_HALT_ON_FAIL_EN. When it is defined,
// the first mismatch ends the run at once.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples; start is ignored
// DONE  | run complete, verdict held; start begins a new run
module orgate_checker #(
  parameter int WIDTH       = 3,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS);

  state_t           state;
  logic             fail_seen;
  logic             mismatch;
  logic             end_run;
  logic             start_run;
  logic [CNT_W-1:0] vec_cnt_inc;

  // Per-sample compare, and the decision whether this sample closes the run
  always_comb begin
    mismatch    = (c != (a | b));
    vec_cnt_inc = vec_cnt + CNT_W'(1);
    start_run   = start && ((state == IDLE) || (state == DONE));
`ifdef ORGATE_CHECKER_HALT_ON_FAIL_EN
    end_run     = (vec_cnt_inc == LAST_VEC) || mismatch;
`else
    end_run     = (vec_cnt_inc == LAST_VEC);
`endif
  end

  // The verdict depends only on registered terms
  assign pass = done & (err_cnt == '0);

  // Run-control FSM with the counters and the first-fail capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_c    <= '0;
      fail_seen <= 1'b0;
    end else if (start_run) begin
      // A start while in DONE takes priority over a sample in the same cycle
      state     <= RUN;
      busy      <= 1'b1;
      done      <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_c    <= '0;
      fail_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (sample_valid) begin
            vec_cnt <= vec_cnt_inc;
            if (mismatch) begin
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
              if (!fail_seen) begin
                fail_seen <= 1'b1;
                fail_idx  <= vec_cnt;
                fail_a    <= a;
                fail_b    <= b;
                fail_c    <= c;
              end
            end
            if (end_run) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: ;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orgate_checker.sv
// Testbench for orgate_checker. It uses directed scenarios plus randomized runs.
// The runs are scored against a vector-list reference model.
module tb_orgate_checker;

  localparam int W  = 3;
  localparam int NV = 4;
  localparam int CW = 8;
  localparam int SW = 3 + 3 * CW + 3 * W;

`ifdef ORGATE_CHECKER_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sample_valid;
  logic [W-1:0]  a, b, c;
  logic          busy, done, pass;
  logic [CW-1:0] vec_cnt, err_cnt, fail_idx;
  logic [W-1:0]  fail_a, fail_b, fail_c;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] sa [NV];
  logic [W-1:0] sb [NV];
  logic [W-1:0] sc [NV];

  orgate_checker #(.WIDTH(W), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .fail_idx(fail_idx),
    .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c)
  );

  always #5 clk = ~clk;

  // Snapshot of every output, packed as {busy,done,pass,vec,err,idx,fa,fb,fc}
  function automatic logic [SW-1:0] snap();
    return {busy, done, pass, vec_cnt, err_cnt, fail_idx, fail_a, fail_b, fail_c};
  endfunction

  // Reference: expected DONE-state outputs for the vectors held in sa/sb/sc
  function automatic logic [SW-1:0] model_final();
    int consumed = NV;
    int errs     = 0;
    int first    = 0;
    bit found    = 0;
    logic [W-1:0] fa = '0, fb = '0, fc = '0;
    for (int i = 0; i < NV; i++) begin
      if (sc[i] != (sa[i] | sb[i])) begin
        if (!found) begin
          found = 1; first = i; fa = sa[i]; fb = sb[i]; fc = sc[i];
        end
        errs++;
        if (HALT) begin
          consumed = i + 1;
          break;
        end
      end
    end
    return {1'b0, 1'b1, (errs == 0), CW'(consumed), CW'(errs), CW'(first), fa, fb, fc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    sample_valid = 1'b1;
    a = x; b = y; c = z;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic load(input logic [3*W-1:0] v0, input logic [3*W-1:0] v1,
                      input logic [3*W-1:0] v2, input logic [3*W-1:0] v3);
    {sa[0], sb[0], sc[0]} = v0;
    {sa[1], sb[1], sc[1]} = v1;
    {sa[2], sb[2], sc[2]} = v2;
    {sa[3], sb[3], sc[3]} = v3;
  endtask

  task automatic test_reset();
    logic [SW-1:0] got;
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0; a = '0; b = '0; c = '0;
    #1;
    got = snap();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_values got=%h exp=%h", got, {SW{1'b0}});
    end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) apply(3'd7, 3'd1, 3'd2);
    got = snap();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL idle_ignores_samples got=%h exp=%h", got, {SW{1'b0}});
    end
  endtask

  task automatic test_good_run();
    logic [SW-1:0] got, exp;
    load({3'd0, 3'd0, 3'd0}, {3'd7, 3'd2, 3'd7}, {3'd7, 3'd6, 3'd7}, {3'd2, 3'd6, 3'd6});
    do_start();
    got = snap();
    exp = {1'b1, 1'b0, 1'b0, {3*CW+3*W{1'b0}}};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL good_after_start got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < NV; i++) apply(sa[i], sb[i], sc[i]);
    got = snap();
    exp = {1'b0, 1'b1, 1'b1, CW'(4), CW'(0), CW'(0), 3'd0, 3'd0, 3'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL good_run_done got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_faulty_run();
    logic [SW-1:0] got, exp;
    load({3'd0, 3'd0, 3'd0}, {3'd7, 3'd2, 3'd5}, {3'd7, 3'd6, 3'd7}, {3'd2, 3'd6, 3'd2});
    do_start();
    apply(sa[0], sb[0], sc[0]);
    apply(sa[1], sb[1], sc[1]);
    got = snap();
    exp = HALT ? {1'b0, 1'b1, 1'b0, CW'(2), CW'(1), CW'(1), 3'd7, 3'd2, 3'd5}
               : {1'b1, 1'b0, 1'b0, CW'(2), CW'(1), CW'(1), 3'd7, 3'd2, 3'd5};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL faulty_after_2nd got=%h exp=%h", got, exp);
    end
    apply(sa[2], sb[2], sc[2]);
    apply(sa[3], sb[3], sc[3]);
    got = snap();
    exp = HALT ? {1'b0, 1'b1, 1'b0, CW'(2), CW'(1), CW'(1), 3'd7, 3'd2, 3'd5}
               : {1'b0, 1'b1, 1'b0, CW'(4), CW'(2), CW'(1), 3'd7, 3'd2, 3'd5};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL faulty_final got=%h exp=%h", got, exp);
    end
    exp = model_final();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL faulty_vs_model got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [SW-1:0] got, exp;
    do_start();
    apply(3'd7, 3'd2, 3'd1);
    apply(3'd1, 3'd2, 3'd3);
    rst = 1'b1;
    #2;
    got = snap();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run_async got=%h exp=%h", got, {SW{1'b0}});
    end
    tick();
    rst = 1'b0;
    tick();
    got = snap();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run_idle got=%h exp=%h", got, {SW{1'b0}});
    end
    load({3'd1, 3'd2, 3'd3}, {3'd4, 3'd0, 3'd4}, {3'd5, 3'd2, 3'd7}, {3'd0, 3'd6, 3'd6});
    do_start();
    for (int i = 0; i < NV; i++) apply(sa[i], sb[i], sc[i]);
    got = snap();
    exp = {1'b0, 1'b1, 1'b1, CW'(4), CW'(0), CW'(0), 3'd0, 3'd0, 3'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_then_good got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_restart_same_cycle();
    logic [SW-1:0] got, exp;
    start = 1'b1;
    apply(3'd1, 3'd1, 3'd0);
    start = 1'b0;
    got = snap();
    exp = {1'b1, 1'b0, 1'b0, {3*CW+3*W{1'b0}}};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL restart_sample_dropped got=%h exp=%h", got, exp);
    end
    load({3'd3, 3'd4, 3'd7}, {3'd0, 3'd1, 3'd1}, {3'd2, 3'd2, 3'd2}, {3'd6, 3'd1, 3'd7});
    for (int i = 0; i < NV; i++) apply(sa[i], sb[i], sc[i]);
    got = snap();
    exp = {1'b0, 1'b1, 1'b1, CW'(4), CW'(0), CW'(0), 3'd0, 3'd0, 3'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL restart_run_done got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_random_runs();
    logic [SW-1:0] got, exp;
    int consumed;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NV; i++) begin
        sa[i] = W'($urandom);
        sb[i] = W'($urandom);
        sc[i] = ($urandom_range(0, 2) == 0) ? W'($urandom) : (sa[i] | sb[i]);
      end
      exp = model_final();
      consumed = int'(exp[3*CW+3*W-1 -: CW]);
      do_start();
      for (int i = 0; i < NV; i++) begin
        // Idle gaps with noise on the data lines; stray starts only while still running
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          a = W'($urandom); b = W'($urandom); c = W'($urandom);
          start = (i < consumed) && ($urandom_range(0, 3) == 0);
          tick();
          start = 1'b0;
        end
        apply(sa[i], sb[i], sc[i]);
      end
      got = snap();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_run_%0d got=%h exp=%h", r, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_faulty_run();
    test_reset_mid_run();
    test_restart_same_cycle();
    test_random_runs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
